// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one off-chip memory port between the I-cache
// (read-only) and the D-cache (read/write-back). One block transfer is in
// flight at a time. Ties are broken round-robin. Address and write data are
// latched at grant, and per-requester grant counters saturate.
module cache_mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_read,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_ready,
   input  logic              dc_read,
   input  logic              dc_write,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  ic_grants,
   output logic [CNT_W-1:0]  dc_grants
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } owner_t;

   state_t state, state_nxt;
   owner_t last_grant;
   logic   ic_pend, dc_pend;
   logic   grant_i, grant_d;

   assign ic_pend = ic_read;
   // A simultaneous read and write from the D-cache is treated as a write.
   assign dc_pend = dc_read | dc_write;

   // Next-state and grant decision; ties go to whoever was not served last.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so
      // no path through the case leaves it unassigned (which would infer a latch).
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (dc_pend && (!ic_pend || last_grant == GNT_I)) begin
               grant_d   = 1'b1;
               state_nxt = D_BUSY;
            end else if (ic_pend) begin
               grant_i   = 1'b1;
               state_nxt = I_BUSY;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Memory-side request registers: latched at grant, frozen while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         last_grant <= GNT_I;
      end else if (grant_d) begin
         mem_addr   <= dc_addr;
         mem_wdata  <= dc_wdata;
         mem_write  <= dc_write;
         mem_read   <= ~dc_write;
         last_grant <= GNT_D;
      end else if (grant_i) begin
         mem_addr   <= ic_addr;
         mem_write  <= 1'b0;
         mem_read   <= 1'b1;
         last_grant <= GNT_I;
      end else if (state != IDLE && mem_ready) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   // Completion is qualified by state, so mem_ready in IDLE has no effect.
   assign ic_ready = (state == I_BUSY) && mem_ready;
   assign dc_ready = (state == D_BUSY) && mem_ready;
   assign ic_rdata = mem_rdata;
   assign dc_rdata = mem_rdata;

   // Saturating completed-transfer counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ic_grants <= '0;
         dc_grants <= '0;
      end else begin
         if (ic_ready && ic_grants != '1) ic_grants <= ic_grants + CNT_W'(1);
         if (dc_ready && dc_grants != '1) dc_grants <= dc_grants + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus tasks push expected
// memory requests and ready responses; two monitors pop and compare them.
module tb_cache_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   // Narrow counters so saturation is reachable in a short run.
   localparam int CNT_W  = 8;
   localparam int SAT_N  = (1 << CNT_W) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_read, dc_read, dc_write;
   logic [ADDR_W-1:0] ic_addr, dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic [DATA_W-1:0] ic_rdata, dc_rdata;
   logic              ic_ready, dc_ready;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [CNT_W-1:0]  ic_grants, dc_grants;

   typedef struct {
      bit                is_d;
      logic [DATA_W-1:0] data;
   } resp_t;

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mtx_t;

   resp_t resp_q[$];
   mtx_t  mem_q[$];

   int checks = 0;
   int errors = 0;

   // Memory model state
   int                mem_lat = 4;
   int                mem_cnt = 0;
   logic [DATA_W-1:0] mem_data = '0;

   assign mem_rdata = mem_data;

   cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .ic_read   (ic_read),
      .ic_addr   (ic_addr),
      .ic_rdata  (ic_rdata),
      .ic_ready  (ic_ready),
      .dc_read   (dc_read),
      .dc_write  (dc_write),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .dc_rdata  (dc_rdata),
      .dc_ready  (dc_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .ic_grants (ic_grants),
      .dc_grants (dc_grants)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: replies mem_lat cycles after the strobe rises, one-cycle pulse.
   initial begin
      mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
         end else if (mem_read || mem_write) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) mem_ready = 1'b1;
         end else begin
            mem_cnt = 0;
         end
      end
   end

   // Response monitor: every ready pulse must match the next expected response.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (ic_ready && dc_ready) begin
            checks++;
            errors++;
            $display("FAIL both_ready: ic_ready and dc_ready high together");
         end else if (ic_ready || dc_ready) begin
            if (resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: ic_ready=%0b dc_ready=%0b with none expected",
                        ic_ready, dc_ready);
            end else begin
               r = resp_q.pop_front();
               check("ready_owner", DATA_W'(dc_ready), DATA_W'(r.is_d));
               check("rdata", r.is_d ? dc_rdata : ic_rdata, r.data);
            end
         end
      end
   end

   // Memory-side monitor: each strobe rise must match the next expected
   // request, and the address must stay put while the strobe is high.
   initial begin
      mtx_t cur;
      bit   prev_stb = 1'b0;
      cur = '{wr: 1'b0, addr: '0, wdata: '0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stb = 1'b0;
         end else if (mem_read || mem_write) begin
            if (!prev_stb) begin
               if (mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe: addr %h", mem_addr);
               end else begin
                  cur = mem_q.pop_front();
                  check("mem_write", DATA_W'(mem_write), DATA_W'(cur.wr));
                  check("mem_read", DATA_W'(mem_read), DATA_W'(!cur.wr));
                  check("mem_addr", DATA_W'(mem_addr), DATA_W'(cur.addr));
                  if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
               end
            end else begin
               check("mem_addr_stable", DATA_W'(mem_addr), DATA_W'(cur.addr));
            end
            prev_stb = 1'b1;
         end else begin
            prev_stb = 1'b0;
         end
      end
   end

   // Wait (bounded) for the requester's ready, then drop its request on that edge.
   task automatic wait_drop(input bit is_d);
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (is_d ? dc_ready : ic_ready) begin
            got = 1'b1;
            break;
         end
      end
      check(is_d ? "dc_ready_timeout" : "ic_ready_timeout", DATA_W'(got), DATA_W'(1));
      @(posedge clk);
      #1;
      if (is_d) begin
         dc_read  = 1'b0;
         dc_write = 1'b0;
      end else begin
         ic_read = 1'b0;
      end
   endtask

   task automatic expect_mem(input bit wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
      mtx_t m;
      m.wr    = wr;
      m.addr  = addr;
      m.wdata = wdata;
      mem_q.push_back(m);
   endtask

   task automatic expect_resp(input bit is_d, input logic [DATA_W-1:0] data);
      resp_t r;
      r.is_d = is_d;
      r.data = data;
      resp_q.push_back(r);
   endtask

   task automatic issue_ic(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input int lat);
      mem_data = data;
      mem_lat  = lat;
      expect_mem(1'b0, addr, '0);
      expect_resp(1'b0, data);
      ic_addr  = addr;
      ic_read  = 1'b1;
      wait_drop(1'b0);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      ic_read  = 1'b0;
      dc_read  = 1'b0;
      dc_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      ic_read  = 1'b0;
      dc_read  = 1'b0;
      dc_write = 1'b0;
      ic_addr  = '0;
      dc_addr  = '0;
      dc_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      check("rst_mem_read", DATA_W'(mem_read), DATA_W'(0));
      check("rst_mem_write", DATA_W'(mem_write), DATA_W'(0));
      check("rst_mem_addr", DATA_W'(mem_addr), DATA_W'(0));
      check("rst_mem_wdata", mem_wdata, DATA_W'(0));
      check("rst_ic_grants", DATA_W'(ic_grants), DATA_W'(0));
      check("rst_dc_grants", DATA_W'(dc_grants), DATA_W'(0));
      rst = 1'b1;

      // Single I-cache read, strobe one cycle after request
      mem_data = {16{8'hA5}};
      mem_lat  = 4;
      expect_mem(1'b0, 28'h0000010, '0);
      expect_resp(1'b0, {16{8'hA5}});
      ic_addr = 28'h0000010;
      ic_read = 1'b1;
      @(negedge clk);
      check("strobe_cycle_n", DATA_W'(mem_read), DATA_W'(0));
      @(negedge clk);
      check("strobe_cycle_n1", DATA_W'(mem_read), DATA_W'(1));
      wait_drop(1'b0);
      check("t1_ic_grants", DATA_W'(ic_grants), DATA_W'(1));
      check("t1_dc_grants", DATA_W'(dc_grants), DATA_W'(0));
      @(negedge clk);
      check("t1_strobe_low", DATA_W'(mem_read), DATA_W'(0));

      // D-cache write-back
      apply_reset();
      mem_lat  = 3;
      mem_data = {4{32'hDEADBEEF}};
      dc_addr  = 28'h00000FF;
      dc_wdata = {32'h5DFDFFFF, 32'hFFFF0123, 32'h456789AB, 32'hCDEF0011};
      expect_mem(1'b1, 28'h00000FF, dc_wdata);
      expect_resp(1'b1, {4{32'hDEADBEEF}});
      dc_write = 1'b1;
      wait_drop(1'b1);
      check("t2_dc_grants", DATA_W'(dc_grants), DATA_W'(1));
      check("t2_ic_grants", DATA_W'(ic_grants), DATA_W'(0));

      // Simultaneous requests from reset: D, then I, then D on the next tie
      apply_reset();
      mem_lat  = 2;
      mem_data = {8{16'h1234}};
      expect_mem(1'b0, 28'h0000040, '0);
      expect_resp(1'b1, {8{16'h1234}});
      expect_mem(1'b0, 28'h0000030, '0);
      expect_resp(1'b0, {8{16'h1234}});
      ic_addr = 28'h0000030;
      dc_addr = 28'h0000040;
      ic_read = 1'b1;
      dc_read = 1'b1;
      wait_drop(1'b1);
      wait_drop(1'b0);
      expect_mem(1'b0, 28'h0000044, '0);
      expect_resp(1'b1, {8{16'h1234}});
      expect_mem(1'b0, 28'h0000034, '0);
      expect_resp(1'b0, {8{16'h1234}});
      ic_addr = 28'h0000034;
      dc_addr = 28'h0000044;
      ic_read = 1'b1;
      dc_read = 1'b1;
      wait_drop(1'b1);
      check("tie_ic_grants", DATA_W'(ic_grants), DATA_W'(1));
      check("tie_dc_grants", DATA_W'(dc_grants), DATA_W'(2));
      wait_drop(1'b0);
      check("tie_ic_grants_final", DATA_W'(ic_grants), DATA_W'(2));

      // Illegal read+write from D-cache behaves as a write
      apply_reset();
      mem_lat  = 1;
      dc_addr  = 28'h0ABCDEF;
      dc_wdata = {4{32'h0F0F0F0F}};
      expect_mem(1'b1, 28'h0ABCDEF, {4{32'h0F0F0F0F}});
      expect_resp(1'b1, {8{16'h1234}});
      dc_read  = 1'b1;
      dc_write = 1'b1;
      wait_drop(1'b1);

      // Address change while busy is ignored
      apply_reset();
      mem_data = {4{32'hCAFEF00D}};
      mem_lat  = 6;
      expect_mem(1'b0, 28'h0000010, '0);
      expect_resp(1'b0, {4{32'hCAFEF00D}});
      ic_addr = 28'h0000010;
      ic_read = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ic_addr = 28'h0000020;
      wait_drop(1'b0);
      check("busy_mem_addr", DATA_W'(mem_addr), DATA_W'(28'h0000010));

      // Reset mid-transfer
      apply_reset();
      issue_ic(28'h0000050, {4{32'h11112222}}, 2);
      check("pre_abort_ic_grants", DATA_W'(ic_grants), DATA_W'(1));
      mem_lat = 8;
      expect_mem(1'b0, 28'h0000054, '0);
      ic_addr = 28'h0000054;
      ic_read = 1'b1;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_read) begin
               seen = 1'b1;
               break;
            end
         end
         check("abort_strobe_seen", DATA_W'(seen), DATA_W'(1));
      end
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      ic_read = 1'b0;
      #1;
      check("abort_mem_read_async", DATA_W'(mem_read), DATA_W'(0));
      check("abort_no_ready", DATA_W'(ic_ready), DATA_W'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      check("abort_ic_grants", DATA_W'(ic_grants), DATA_W'(0));
      issue_ic(28'h0000058, {4{32'h33334444}}, 3);
      check("post_abort_ic_grants", DATA_W'(ic_grants), DATA_W'(1));

      // Saturation: SAT_N back-to-back I-cache transfers
      apply_reset();
      mem_lat  = 1;
      mem_data = {4{32'h77778888}};
      for (int i = 0; i < SAT_N; i++) begin
         expect_mem(1'b0, 28'h0000060, '0);
         expect_resp(1'b0, {4{32'h77778888}});
      end
      ic_addr = 28'h0000060;
      ic_read = 1'b1;
      begin
         int n = 0;
         for (int i = 0; i < 4 * SAT_N && n < SAT_N; i++) begin
            @(negedge clk);
            if (ic_ready) n++;
         end
         check("sat_transfers", DATA_W'(n), DATA_W'(SAT_N));
      end
      @(posedge clk);
      #1;
      ic_read = 1'b0;
      check("sat_ic_grants", DATA_W'(ic_grants), DATA_W'({CNT_W{1'b1}}));
      check("sat_dc_grants", DATA_W'(dc_grants), DATA_W'(0));

      repeat (4) @(negedge clk);
      check("resp_q_drained", DATA_W'(resp_q.size()), DATA_W'(0));
      check("mem_q_drained", DATA_W'(mem_q.size()), DATA_W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single off-chip memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined RISC-V core. Serves one outstanding block transfer at a time and round-robins on contention so neither cache starves. Latches address and write data at grant time, and keeps per-requester grant counters for the test bench's duration/performance reporting.

## Interface
- ADDR_W, 28, block address width
- DATA_W, 128, block width in bits
- CNT_W, 16, grant counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- ic_read  in  1  I-cache block read request, held until ic_ready
- ic_addr  in  ADDR_W  I-cache block address
- ic_rdata  out  DATA_W  read data to I-cache
- ic_ready  out  1  I-cache transfer complete, one-cycle pulse
- dc_read  in  1  D-cache block read request, held until dc_ready
- dc_write  in  1  D-cache block write-back request, held until dc_ready
- dc_addr  in  ADDR_W  D-cache block address
- dc_wdata  in  DATA_W  D-cache write data
- dc_rdata  out  DATA_W  read data to D-cache
- dc_ready  out  1  D-cache transfer complete, one-cycle pulse
- mem_read  out  1  memory read strobe, registered
- mem_write  out  1  memory write strobe, registered
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory transfer complete, one-cycle pulse
- ic_grants  out  CNT_W  completed I-cache transfers, saturating
- dc_grants  out  CNT_W  completed D-cache transfers, saturating

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE, exactly one requester pending: grant to it.
- IDLE, both pending: grant to the requester not recorded in last_grant.
- last_grant resets to I-cache, so the first tie goes to the D-cache.
- On grant:
  - latch addr (and dc_wdata for D) into mem_addr/mem_wdata.
  - set mem_read, or mem_write for a D-cache write.
  - update last_grant.
- dc_read and dc_write both high is illegal; the arbiter treats it as a write.
- BUSY:
  - hold mem_* stable.
  - ignore changes on requester address/data inputs.
  - on mem_ready: pulse the granted requester's ready, return to IDLE, clear mem_read/mem_write, increment that requester's grant counter.
- ic_rdata and dc_rdata are both driven from mem_rdata combinationally. Only the matching ready qualifies the data.
- ic_ready and dc_ready are combinational: (state matches) AND mem_ready. They are never both high.
- mem_ready in IDLE is ignored: no ready pulse, no counter change.
- Grant counters saturate at 2^CNT_W−1 and do not wrap.
- Reset values: state IDLE, last_grant I, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, ic_grants 0, dc_grants 0. ic_ready and dc_ready are 0 by construction.
- Reset asserted mid-transfer:
  - aborts the transfer immediately (asynchronous clear).
  - no ready pulse is issued.
  - memory sees the strobe drop; the memory model must be reset together with the arbiter.

## Timing
- Request seen in IDLE at cycle N → grant on edge ending N → mem_read/mem_write high from cycle N+1.
- mem_ready high in cycle M (M ≥ N+1) → requester ready high in cycle M, with data valid in the same cycle.
- Edge ending M → state IDLE; strobes low from M+1; counter updated at M+1.
- Requesters drop their request on the edge ending M. The arbiter re-evaluates in cycle M+1. Back-to-back transfers therefore have one strobe-low cycle between them.
- Minimum arbiter overhead: one cycle request-to-strobe. No added latency on return.

## Test plan
- Single I-cache read:
  - ic_read=1, ic_addr=28'h0000010; memory replies after 4 cycles with 128'hA5…A5.
  - mem_read high at N+1, mem_addr=28'h0000010.
  - ic_ready one cycle with ic_rdata=A5…A5; dc_ready stays 0; ic_grants=1.
- D-cache write-back:
  - dc_write=1, dc_addr=28'h00000FF, dc_wdata=128'h5D_FD_FF_FF….
  - mem_write high, mem_read low, mem_wdata matches.
  - dc_ready pulses once; dc_grants=1.
- Simultaneous ic_read and dc_read from reset:
  - D is served first, then I, after one idle cycle.
  - A third tie goes to D again (alternation); final counts ic_grants=1, dc_grants=2.
- Input change while BUSY:
  - ic_addr changes from 0x10 to 0x20 mid-transfer.
  - mem_addr stays 0x10 throughout.
- Reset mid-transfer:
  - rst low 2 cycles after the strobe rises.
  - mem_read drops without waiting for a clock; no ready pulse.
  - After release, counters are 0 and a new request is granted normally.
- Saturation:
  - Force 65 537 I-cache transfers with CNT_W=16.
  - ic_grants holds at 16'hFFFF.
